// File: rtl/risc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : risc_pkg
//  Description : Shared datapath constants, ALU op and write-condition
//                encodings for the 16-bit RISC core.
//  Revision    : 1.0  initial release
// ============================================================================
package risc_pkg;

    localparam int DATA_W = 16;
    localparam int REG_AW = 3;

    typedef enum logic [1:0] {
        ALU_ADD  = 2'b00,
        ALU_SUB  = 2'b01,
        ALU_CMP  = 2'b10,
        ALU_NAND = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        COND_ALWAYS = 2'b00,
        COND_IF_C   = 2'b01,
        COND_IF_Z   = 2'b10,
        COND_NEVER  = 2'b11
    } cond_e;

endpackage : risc_pkg
`default_nettype wire

// File: rtl/ex_wb_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : ex_wb_stage_if
//  Description : ALU-bundle input, writeback, flag and forwarding signals of
//                the EX/WB stage, with a driver (master) and stage (slave) view.
//  Revision    : 1.0  initial release
// ============================================================================
interface ex_wb_stage_if #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 3,
    parameter int CNT_W  = 16
);
    // ALU output bundle
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_alu_ans;
    logic              in_zero;
    logic              in_carry;
    logic [1:0]        in_cond;
    logic [REG_AW-1:0] in_rd;
    logic              in_we;
    logic              in_c_en;
    logic              in_z_en;
    logic              flush;

    // Writeback towards the register file
    logic              wb_valid;
    logic              wb_ready;
    logic              wb_we;
    logic [REG_AW-1:0] wb_rd;
    logic [DATA_W-1:0] wb_data;

    // Architectural flags, forwarding tap and statistics
    logic              flag_z;
    logic              flag_c;
    logic              fwd_valid;
    logic [REG_AW-1:0] fwd_rd;
    logic [DATA_W-1:0] fwd_data;
    logic [CNT_W-1:0]  skip_cnt;

    modport master (
        output in_valid, in_alu_ans, in_zero, in_carry, in_cond, in_rd,
               in_we, in_c_en, in_z_en, flush, wb_ready,
        input  in_ready, wb_valid, wb_we, wb_rd, wb_data, flag_z, flag_c,
               fwd_valid, fwd_rd, fwd_data, skip_cnt
    );

    modport slave (
        input  in_valid, in_alu_ans, in_zero, in_carry, in_cond, in_rd,
               in_we, in_c_en, in_z_en, flush, wb_ready,
        output in_ready, wb_valid, wb_we, wb_rd, wb_data, flag_z, flag_c,
               fwd_valid, fwd_rd, fwd_data, skip_cnt
    );

endinterface : ex_wb_stage_if
`default_nettype wire

// File: rtl/ex_wb_stage_cond_check.sv
`default_nettype none
// ============================================================================
//  Module      : cond_check
//  Description : Evaluates a write/branch condition against the Z/C flags.
//  Revision    : 1.0  initial release
// ============================================================================
module cond_check
    import risc_pkg::*;
(
    input  cond_e cond_i,
    input  logic  flag_z_i,
    input  logic  flag_c_i,
    output logic  pass_o
);

    always_comb begin
        pass_o = 1'b0;
        unique case (cond_i)
            COND_ALWAYS: pass_o = 1'b1;
            COND_IF_C:   pass_o = flag_c_i;
            COND_IF_Z:   pass_o = flag_z_i;
            COND_NEVER:  pass_o = 1'b0;
            default:     pass_o = 1'b0;
        endcase
    end

endmodule : cond_check
`default_nettype wire

// File: rtl/ex_wb_stage.sv
`default_nettype none
// ============================================================================
//  Module      : ex_wb_stage
//  Description : ALU pipeline register with conditional flag commit, a single
//                registered writeback slot and a forwarding tap.
//  Revision    : 1.0  initial release
// ============================================================================
module ex_wb_stage #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 3,
    parameter int CNT_W  = 16
) (
    input  wire logic         clk,
    input  wire logic         rst,
    ex_wb_stage_if.slave      bus
);
    import risc_pkg::*;

    logic              wb_valid_q, wb_valid_d;
    logic              wb_we_q,    wb_we_d;
    logic [REG_AW-1:0] wb_rd_q,    wb_rd_d;
    logic [DATA_W-1:0] wb_data_q,  wb_data_d;
    logic              flag_z_q,   flag_z_d;
    logic              flag_c_q,   flag_c_d;
    logic [CNT_W-1:0]  skip_cnt_q, skip_cnt_d;

    logic w_in_ready;
    logic w_accept;
    logic w_pass;

    // Ready never looks at in_valid, so upstream can compute valid freely.
    assign w_in_ready = !bus.flush && (!wb_valid_q || bus.wb_ready);
    assign w_accept   = bus.in_valid && w_in_ready;

    // Condition sees the flags as they stand before this bundle commits.
    cond_check u_cond_check (
        .cond_i   (cond_e'(bus.in_cond)),
        .flag_z_i (flag_z_q),
        .flag_c_i (flag_c_q),
        .pass_o   (w_pass)
    );

    always_comb begin
        wb_valid_d = wb_valid_q;
        wb_we_d    = wb_we_q;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;
        flag_z_d   = flag_z_q;
        flag_c_d   = flag_c_q;
        skip_cnt_d = skip_cnt_q;

        if (bus.flush) begin
            wb_valid_d = 1'b0;
            wb_we_d    = 1'b0;
        end else if (w_accept) begin
            // A failed bundle still occupies the slot to keep ordering.
            wb_valid_d = 1'b1;
            wb_we_d    = bus.in_we && w_pass;
            wb_rd_d    = bus.in_rd;
            wb_data_d  = bus.in_alu_ans;
            if (w_pass) begin
                if (bus.in_c_en) flag_c_d = bus.in_carry;
                if (bus.in_z_en) flag_z_d = bus.in_zero;
            end else begin
                skip_cnt_d = skip_cnt_q + 1'b1;
            end
        end else if (wb_valid_q && bus.wb_ready) begin
            wb_valid_d = 1'b0;
            wb_we_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid_q <= 1'b0;
            wb_we_q    <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            flag_z_q   <= 1'b0;
            flag_c_q   <= 1'b0;
            skip_cnt_q <= '0;
        end else begin
            wb_valid_q <= wb_valid_d;
            wb_we_q    <= wb_we_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
            flag_z_q   <= flag_z_d;
            flag_c_q   <= flag_c_d;
            skip_cnt_q <= skip_cnt_d;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.wb_valid  = wb_valid_q;
    assign bus.wb_we     = wb_we_q;
    assign bus.wb_rd     = wb_rd_q;
    assign bus.wb_data   = wb_data_q;
    assign bus.flag_z    = flag_z_q;
    assign bus.flag_c    = flag_c_q;
    assign bus.fwd_valid = wb_valid_q && wb_we_q;
    assign bus.fwd_rd    = wb_rd_q;
    assign bus.fwd_data  = wb_data_q;
    assign bus.skip_cnt  = skip_cnt_q;

endmodule : ex_wb_stage
`default_nettype wire

// File: tb/tb_ex_wb_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ex_wb_stage
//  Description : Directed and random self-checking bench for ex_wb_stage.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ex_wb_stage;

    logic clk;
    logic rst;

    ex_wb_stage_if #(.DATA_W(16), .REG_AW(3), .CNT_W(16)) bus ();

    ex_wb_stage #(.DATA_W(16), .REG_AW(3), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert;
    int n_fail;

    // Reference state of the stage as the rules describe it
    logic        m_valid, m_we, m_z, m_c;
    logic [2:0]  m_rd;
    logic [15:0] m_data;
    logic [15:0] m_skip;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, " wb_valid"},  32'(bus.wb_valid),  32'(m_valid));
        chk({tag, " wb_we"},     32'(bus.wb_we),     32'(m_we));
        chk({tag, " wb_rd"},     32'(bus.wb_rd),     32'(m_rd));
        chk({tag, " wb_data"},   32'(bus.wb_data),   32'(m_data));
        chk({tag, " flag_z"},    32'(bus.flag_z),    32'(m_z));
        chk({tag, " flag_c"},    32'(bus.flag_c),    32'(m_c));
        chk({tag, " fwd_valid"}, 32'(bus.fwd_valid), 32'(m_valid && m_we));
        chk({tag, " fwd_rd"},    32'(bus.fwd_rd),    32'(m_rd));
        chk({tag, " fwd_data"},  32'(bus.fwd_data),  32'(m_data));
        chk({tag, " skip_cnt"},  32'(bus.skip_cnt),  32'(m_skip));
    endtask

    // One clock: drive at negedge, check ready, step the model at posedge, check state.
    task automatic cycle(input string tag, input logic v, input logic [15:0] ans,
                         input logic z, input logic c, input logic [1:0] cond,
                         input logic [2:0] rd, input logic we, input logic cen,
                         input logic zen, input logic fl, input logic wr, input logic r);
        logic acc, pass;
        rst            = r;
        bus.in_valid   = v;
        bus.in_alu_ans = ans;
        bus.in_zero    = z;
        bus.in_carry   = c;
        bus.in_cond    = cond;
        bus.in_rd      = rd;
        bus.in_we      = we;
        bus.in_c_en    = cen;
        bus.in_z_en    = zen;
        bus.flush      = fl;
        bus.wb_ready   = wr;
        #1;
        chk({tag, " in_ready"}, 32'(bus.in_ready), 32'(!fl && (!m_valid || wr)));
        @(posedge clk);
        acc  = v && !fl && (!m_valid || wr);
        pass = (cond == 2'd0) ? 1'b1 : (cond == 2'd1) ? m_c : (cond == 2'd2) ? m_z : 1'b0;
        if (r) begin
            {m_valid, m_we, m_z, m_c} = '0;
            m_rd = '0; m_data = '0; m_skip = '0;
        end else if (fl) begin
            m_valid = 1'b0; m_we = 1'b0;
        end else if (acc) begin
            m_valid = 1'b1;
            m_we    = we && pass;
            m_rd    = rd;
            m_data  = ans;
            if (pass) begin
                if (cen) m_c = c;
                if (zen) m_z = z;
            end else begin
                m_skip = m_skip + 16'd1;
            end
        end else if (m_valid && wr) begin
            m_valid = 1'b0; m_we = 1'b0;
        end
        #1;
        check_all(tag);
        @(negedge clk);
    endtask

    task automatic idle(input string tag, input logic wr);
        cycle(tag, 1'b0, 16'h0, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, wr, 1'b0);
    endtask

    initial begin
        logic [15:0] skip0;
        int          guard;
        n_assert = 0;
        n_fail   = 0;
        {m_valid, m_we, m_z, m_c} = '0;
        m_rd = '0; m_data = '0; m_skip = '0;
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_alu_ans = '0; bus.in_zero = 1'b0; bus.in_carry = 1'b0;
        bus.in_cond = 2'd0; bus.in_rd = '0; bus.in_we = 1'b0; bus.in_c_en = 1'b0;
        bus.in_z_en = 1'b0; bus.flush = 1'b0; bus.wb_ready = 1'b0;
        @(negedge clk);

        // Reset state
        cycle("reset", 1'b0, 16'h0, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("reset skip_cnt lit", 32'(bus.skip_cnt), 32'd0);

        // ADD 0xFFFF+1: ans 0, zero 1, carry 1
        cycle("add", 1'b1, 16'h0000, 1'b1, 1'b1, 2'd0, 3'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("add wb_we lit",     32'(bus.wb_we),     32'd1);
        chk("add wb_rd lit",     32'(bus.wb_rd),     32'd3);
        chk("add flags lit",     32'({bus.flag_z, bus.flag_c}), 32'b11);
        chk("add fwd_valid lit", 32'(bus.fwd_valid), 32'd1);

        // Clear C, then IF_C must fail
        cycle("clrc", 1'b1, 16'h0001, 1'b0, 1'b0, 2'd0, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        skip0 = m_skip;
        cycle("ifc", 1'b1, 16'h1234, 1'b0, 1'b1, 2'd1, 3'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("ifc wb_valid lit", 32'(bus.wb_valid), 32'd1);
        chk("ifc wb_we lit",    32'(bus.wb_we),    32'd0);
        chk("ifc flag_c lit",   32'(bus.flag_c),   32'd0);
        chk("ifc skip lit",     32'(bus.skip_cnt), 32'(skip0 + 16'd1));

        // Back-to-back: A sets Z, B (IF_Z) sees it the very next cycle
        cycle("b2b_a", 1'b1, 16'h0000, 1'b1, 1'b0, 2'd0, 3'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        cycle("b2b_b", 1'b1, 16'h00AA, 1'b0, 1'b0, 2'd2, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("b2b wb_we lit",   32'(bus.wb_we),   32'd1);
        chk("b2b wb_data lit", 32'(bus.wb_data), 32'h00AA);
        chk("b2b wb_rd lit",   32'(bus.wb_rd),   32'd5);

        // Stall: entry held, wb_ready low for 3 cycles with a pending bundle
        cycle("stall_ld", 1'b1, 16'h5555, 1'b0, 1'b1, 2'd0, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle("stall", 1'b1, 16'h7777, 1'b0, 1'b0, 2'd0, 3'd6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            chk("stall wb_data lit", 32'(bus.wb_data), 32'h5555);
            chk("stall flag_c lit",  32'(bus.flag_c),  32'd1);
        end
        cycle("unstall", 1'b1, 16'h7777, 1'b0, 1'b0, 2'd0, 3'd6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("unstall wb_data lit", 32'(bus.wb_data), 32'h7777);
        chk("unstall flag_c lit",  32'(bus.flag_c),  32'd0);
        idle("drain", 1'b1);
        chk("drain wb_valid lit", 32'(bus.wb_valid), 32'd0);

        // Flush with an entry held and a Z-setting bundle offered
        cycle("fl_ld", 1'b1, 16'h0042, 1'b0, 1'b0, 2'd0, 3'd7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        skip0 = m_skip;
        cycle("flush", 1'b1, 16'h0000, 1'b1, 1'b0, 2'd0, 3'd1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("flush wb_valid lit", 32'(bus.wb_valid), 32'd0);
        chk("flush flag_z lit",   32'(bus.flag_z),   32'd0);
        chk("flush skip lit",     32'(bus.skip_cnt), 32'(skip0));

        // Push skip_cnt to its maximum, then wrap
        guard = 0;
        while (m_skip != 16'hFFFF && guard < 70000) begin
            cycle("skipfill", 1'b1, 16'(guard), 1'b0, 1'b0, 2'd3, 3'(guard), 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
            guard++;
        end
        chk("skipfill bound", 32'(guard < 70000), 32'd1);
        chk("skip max lit", 32'(bus.skip_cnt), 32'hFFFF);
        cycle("wrap", 1'b1, 16'h1111, 1'b0, 1'b0, 2'd3, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("wrap skip lit", 32'(bus.skip_cnt), 32'h0000);

        // Reset during a stall
        cycle("rs_ld", 1'b1, 16'hBEEF, 1'b1, 1'b1, 2'd0, 3'd6, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        cycle("rs_st", 1'b1, 16'hCAFE, 1'b0, 1'b0, 2'd0, 3'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle("rst_stall", 1'b1, 16'hCAFE, 1'b0, 1'b0, 2'd0, 3'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("rst wb_data lit", 32'(bus.wb_data), 32'd0);
        chk("rst flags lit",   32'({bus.flag_z, bus.flag_c}), 32'd0);
        chk("rst in_ready lit", 32'(bus.in_ready), 32'd1);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            cycle("rand",
                  1'($urandom_range(0, 9) < 7), 16'($urandom), 1'($urandom), 1'($urandom),
                  2'($urandom), 3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 9) < 7),
                  1'($urandom_range(0, 99) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_ex_wb_stage
`default_nettype wire
